// File: rtl/i_axi_lite.sv
`default_nettype none
// ============================================================================
// Module   : i_axi_lite
// Purpose  : Single-outstanding AXI4-Lite master bridge that turns one-shot
//            read/write commands into AXI4-Lite handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module i_axi_lite #(
    parameter  int ADDR_WIDTH = 8,
    parameter  int DATA_WIDTH = 64,
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    // command side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_W-1:0]     cmd_wstrb,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    // write address / data / response channels
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [2:0]            awprot,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [STRB_W-1:0]     wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    // read address / data channels
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    state_t                state_q,     state_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
    logic [STRB_W-1:0]     wstrb_q,     wstrb_d;
    logic                  awvalid_q,   awvalid_d;
    logic                  wvalid_q,    wvalid_d;
    logic                  arvalid_q,   arvalid_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q,  rsp_resp_d;
    logic                  w_aw_done;
    logic                  w_w_done;

    // A channel counts as done once its valid has dropped or is handshaking now
    assign w_aw_done = !awvalid_q || awready;
    assign w_w_done  = !wvalid_q  || wready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    if (cmd_write) begin
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (awvalid_q && awready) awvalid_d = 1'b0;
                if (wvalid_q && wready)   wvalid_d  = 1'b0;
                if (w_aw_done && w_w_done) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (bvalid) begin
                    rsp_resp_d  = bresp;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            RD_REQ: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid) begin
                    rsp_resp_d  = rresp;
                    rsp_rdata_d = rdata;
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    // Ready is held low while reset is asserted, even though the FSM sits in IDLE
    assign cmd_ready = (state_q == IDLE) && reset;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign awaddr    = addr_q;
    assign awprot    = 3'b000;
    assign awvalid   = awvalid_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign wvalid    = wvalid_q;
    assign bready    = (state_q == WR_RESP);
    assign araddr    = addr_q;
    assign arprot    = 3'b000;
    assign arvalid   = arvalid_q;
    assign rready    = (state_q == RD_DATA);

endmodule
`default_nettype wire

// File: tb/tb_i_axi_lite.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_i_axi_lite
// Purpose  : Self-checking bench for i_axi_lite with a delay-programmable
//            AXI4-Lite slave and a memory/latency reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i_axi_lite;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [63:0] cmd_wdata = '0;
    logic [7:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, arvalid, bready, rready;
    logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [1:0]  bresp = '0, rresp = '0;
    logic        bvalid = 1'b0, rvalid = 1'b0;
    logic [63:0] rdata = '0;

    i_axi_lite #(.ADDR_WIDTH(8), .DATA_WIDTH(64)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [63:0] rdata;
        logic [1:0]  resp;
    } rsp_t;
    rsp_t exp_q[$];

    logic [63:0] ref_mem   [32];
    logic [63:0] slave_mem [32];

    // Slave configuration, set by the stimulus before each command
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    logic [7:0]  cur_addr = '0;
    logic [63:0] cur_wdata = '0;
    logic [7:0]  cur_wstrb = '0;
    logic [1:0]  sl_resp = '0;
    bit          rand_in_reset = 1'b1;

    // Slave state
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    bit          aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0, b_drop = 0, r_drop = 0;
    bit          aw_fire, w_fire, ar_fire;
    bit          aw_fire_p = 0, w_fire_p = 0, ar_fire_p = 0;
    bit          awv_p = 0, wv_p = 0, arv_p = 0;
    logic [7:0]  aw_a = '0, ar_a = '0, awaddr_p = '0, araddr_p = '0;
    logic [63:0] w_d = '0, wdata_p = '0, mask;

    // Slave: decides its inputs on the falling edge; a valid&ready seen here
    // becomes a handshake on the following rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; b_drop = 0; r_drop = 0;
            aw_fire_p = 0; w_fire_p = 0; ar_fire_p = 0; awv_p = 0; wv_p = 0; arv_p = 0;
            if (rand_in_reset) begin
                awready = 1'($urandom); wready = 1'($urandom); arready = 1'($urandom);
                bvalid = 1'($urandom); rvalid = 1'($urandom);
                bresp = 2'($urandom); rresp = 2'($urandom); rdata = {$urandom, $urandom};
            end else begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            end
        end else begin
            if (aw_fire_p) check_eq("awvalid_drop", 64'(awvalid), 0);
            else if (awv_p && awvalid) check_eq("awaddr_stable", 64'(awaddr), 64'(awaddr_p));
            if (w_fire_p) check_eq("wvalid_drop", 64'(wvalid), 0);
            else if (wv_p && wvalid) check_eq("wdata_stable", wdata, wdata_p);
            if (ar_fire_p) check_eq("arvalid_drop", 64'(arvalid), 0);
            else if (arv_p && arvalid) check_eq("araddr_stable", 64'(araddr), 64'(araddr_p));

            if (b_drop) begin bvalid = 0; b_drop = 0; end
            if (r_drop) begin rvalid = 0; r_drop = 0; end
            if (b_pend) begin
                if (b_cnt >= b_dly) begin bvalid = 1; bresp = sl_resp; b_pend = 0; end
                else b_cnt++;
            end
            if (bvalid && bready) b_drop = 1;
            if (r_pend) begin
                if (r_cnt >= r_dly) begin
                    rvalid = 1; rresp = sl_resp; rdata = slave_mem[ar_a[7:3]]; r_pend = 0;
                end else r_cnt++;
            end
            if (rvalid && rready) r_drop = 1;

            awready = awvalid && (aw_cnt >= aw_dly);
            if (awvalid && !awready) aw_cnt++;
            aw_fire = awvalid && awready;
            if (aw_fire) begin
                check_eq("awaddr", 64'(awaddr), 64'(cur_addr));
                check_eq("awprot", 64'(awprot), 0);
                aw_a = awaddr; aw_got = 1; aw_cnt = 0;
            end
            wready = wvalid && (w_cnt >= w_dly);
            if (wvalid && !wready) w_cnt++;
            w_fire = wvalid && wready;
            if (w_fire) begin
                check_eq("wdata", wdata, cur_wdata);
                check_eq("wstrb", 64'(wstrb), 64'(cur_wstrb));
                w_d = wdata; w_got = 1; w_cnt = 0;
                mask = '0;
                for (int i = 0; i < 8; i++) if (wstrb[i]) mask[i*8 +: 8] = 8'hFF;
            end
            if (aw_got && w_got) begin
                if (sl_resp == 2'b00)
                    slave_mem[aw_a[7:3]] = (slave_mem[aw_a[7:3]] & ~mask) | (w_d & mask);
                aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
            end
            arready = arvalid && (ar_cnt >= ar_dly);
            if (arvalid && !arready) ar_cnt++;
            ar_fire = arvalid && arready;
            if (ar_fire) begin
                check_eq("araddr", 64'(araddr), 64'(cur_addr));
                check_eq("arprot", 64'(arprot), 0);
                ar_a = araddr; r_pend = 1; r_cnt = 0; ar_cnt = 0;
            end
            aw_fire_p = aw_fire; w_fire_p = w_fire; ar_fire_p = ar_fire;
            awv_p = awvalid; wv_p = wvalid; arv_p = arvalid;
            awaddr_p = awaddr; wdata_p = wdata; araddr_p = araddr;
        end
    end

    // Response scoreboard
    logic rsp_prev = 1'b0;
    always @(negedge clk) begin
        rsp_t e;
        if (reset && rsp_valid) begin
            check_eq("rsp_pulse", 64'(rsp_prev), 0);
            if (exp_q.size() == 0) check_eq("unexpected_rsp", 1, 0);
            else begin
                e = exp_q.pop_front();
                check_eq("rsp_rdata", rsp_rdata, e.rdata);
                check_eq("rsp_resp", 64'(rsp_resp), 64'(e.resp));
            end
        end
        rsp_prev = reset && rsp_valid;
    end

    // Issues one command starting at a falling edge; returns at the falling
    // edge where rsp_valid is seen, with the cycle count since acceptance.
    task automatic run_cmd(input bit wr, input logic [7:0] a, input logic [63:0] d,
                           input logic [7:0] s, input logic [1:0] r, output int lat);
        rsp_t e;
        cur_addr = a; cur_wdata = d; cur_wstrb = s; sl_resp = r;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        lat = -1;
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        if (!cmd_ready) begin
            check_eq("accept_timeout", 0, 1);
            cmd_valid = 0;
            return;
        end
        e.resp  = r;
        e.rdata = wr ? 64'd0 : ref_mem[a[7:3]];
        if (wr && r == 2'b00)
            for (int i = 0; i < 8; i++) if (s[i]) ref_mem[a[7:3]][i*8 +: 8] = d[i*8 +: 8];
        exp_q.push_back(e);
        @(negedge clk);
        cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = 8'($urandom);
        cmd_wdata = {$urandom, $urandom};
        for (int n = 1; n <= 100; n++) begin
            if (rsp_valid) begin lat = n; break; end
            @(negedge clk);
        end
        if (lat < 0) check_eq("rsp_timeout", 0, 1);
    endtask

    task automatic set_dly(input int a, input int w, input int ar, input int b, input int r);
        aw_dly = a; w_dly = w; ar_dly = ar; b_dly = b; r_dly = r;
    endtask

    int lat;
    int mx;
    bit wr;
    logic [1:0] rr;

    initial begin
        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = {$urandom, $urandom};
            slave_mem[i] = ref_mem[i];
        end
        // Reset held with random slave and command inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_addr = 8'($urandom);
            #1;
            check_eq("reset_ctrl", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}), 0);
        end
        check_eq("reset_data", {awaddr, araddr, wstrb, 6'(0), rsp_resp}, 0);
        check_eq("reset_rdata", rsp_rdata | wdata, 0);
        cmd_valid = 0;
        @(negedge clk); #2 rand_in_reset = 0;
        @(negedge clk); #2 reset = 1;
        #1 check_eq("ready_after_reset", 64'(cmd_ready), 1);
        @(negedge clk);

        // Zero-wait write
        set_dly(0, 0, 0, 0, 0);
        run_cmd(1, 8'h00, 64'd1000, 8'hFF, 2'b00, lat);
        check_eq("lat_zero_wait", 64'(lat), 3);
        check_eq("ready_at_rsp", 64'(cmd_ready), 1);

        // AW delayed 3 cycles, W immediate, back to back
        set_dly(3, 0, 0, 0, 0);
        run_cmd(1, 8'h20, 64'd0, 8'hFF, 2'b00, lat);
        check_eq("lat_aw_delay_a", 64'(lat), 6);
        run_cmd(1, 8'h10, 64'd10, 8'hFF, 2'b00, lat);
        check_eq("lat_aw_delay_b", 64'(lat), 6);

        // Read with 2-cycle arready delay
        set_dly(0, 0, 2, 0, 0);
        run_cmd(0, 8'h10, 64'd0, 8'h00, 2'b00, lat);
        check_eq("lat_ar_delay", 64'(lat), 5);
        check_eq("rd_0x10", rsp_rdata, 64'd10);

        // Slave error on write, then read back the untouched location
        set_dly(0, 0, 0, 0, 0);
        run_cmd(1, 8'h30, 64'h1234, 8'hFF, 2'b10, lat);
        check_eq("slverr_resp", 64'(rsp_resp), 2);
        check_eq("idle_after_err", 64'(cmd_ready), 1);
        run_cmd(0, 8'h30, 64'd0, 8'h00, 2'b00, lat);

        // Reset while a write is in flight
        set_dly(5, 5, 0, 0, 0);
        cur_addr = 8'h08; cur_wdata = 64'hDEAD; cur_wstrb = 8'hFF; sl_resp = 2'b00;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h08; cmd_wdata = 64'hDEAD; cmd_wstrb = 8'hFF;
        @(negedge clk);
        cmd_valid = 0;
        check_eq("aw_before_reset", 64'({awvalid, wvalid}), 3);
        #2 reset = 0;
        #1 check_eq("valids_async_drop", 64'({awvalid, wvalid, arvalid}), 0);
        @(negedge clk);
        check_eq("no_rsp_in_reset", 64'(rsp_valid), 0);
        #2 reset = 1;
        @(negedge clk);
        check_eq("no_rsp_after_abort", 64'(rsp_valid), 0);
        set_dly(0, 0, 0, 0, 0);
        run_cmd(1, 8'h08, 64'h0123_4567_89AB_CDEF, 8'h0F, 2'b00, lat);
        check_eq("lat_after_abort", 64'(lat), 3);
        run_cmd(0, 8'h08, 64'd0, 8'h00, 2'b00, lat);

        // Randomized traffic with random slave delays and responses
        for (int k = 0; k < 60; k++) begin
            set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 2), $urandom_range(0, 2));
            wr = 1'($urandom);
            rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'b00;
            run_cmd(wr, {5'($urandom), 3'b000}, {$urandom, $urandom}, 8'($urandom), rr, lat);
            mx = (aw_dly > w_dly) ? aw_dly : w_dly;
            if (wr) check_eq("lat_rand_wr", 64'(lat), 64'(3 + mx + b_dly));
            else    check_eq("lat_rand_rd", 64'(lat), 64'(3 + ar_dly + r_dly));
        end

        @(negedge clk);
        check_eq("pending_rsp", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        check_eq("watchdog", 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
